// File: rtl/fp_sum_sequencer_if.sv
// rtl/fp_sum_sequencer_if.sv - handshake and adder-operand bundle for fp_sum_sequencer
interface fp_sum_sequencer_if #(
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic [31:0]      add_op1;
   logic [31:0]      add_op2;
   logic [31:0]      add_res;
   logic             sum_valid;
   logic [31:0]      sum_data;
   logic             sum_ready;
   logic             busy;

   modport master (
      output start, len, in_valid, in_data, add_res, sum_ready,
      input  in_ready, add_op1, add_op2, sum_valid, sum_data, busy
   );

   modport slave (
      input  start, len, in_valid, in_data, add_res, sum_ready,
      output in_ready, add_op1, add_op2, sum_valid, sum_data, busy
   );
endinterface

// File: rtl/fp_sum_sequencer.sv
// rtl/fp_sum_sequencer.sv - length-prefixed float accumulator driving an external adder
module fp_sum_sequencer #(
   parameter int LEN_W = 8
) (
   input logic                clk,
   input logic                rst,
   fp_sum_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= 32'h0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d   = 32'h0;
               cnt_d   = '0;
               len_d   = bus.len;
               state_d = (bus.len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               acc_d = bus.add_res;
               cnt_d = cnt_q + ONE;
               // Compare before increment so len = 2^LEN_W-1 ends without wrap.
               if (cnt_q == len_q - ONE) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (bus.sum_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.sum_valid = (state_q == DONE);
   assign bus.busy      = (state_q == ACCUM) || (state_q == DONE);
   assign bus.sum_data  = (state_q == DONE) ? acc_q : 32'h0;
   assign bus.add_op1   = acc_q;
   assign bus.add_op2   = bus.in_data;
endmodule

// File: tb/tb_fp_sum_sequencer.sv
// tb/tb_fp_sum_sequencer.sv - directed bench for fp_sum_sequencer with a table-driven adder stub
module tb_fp_sum_sequencer;
   localparam int LEN_W = 8;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   accepts;
   int   cycles;

   fp_sum_sequencer_if #(.LEN_W(LEN_W)) bus ();

   fp_sum_sequencer #(.LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adder stand-in: zero operand passes the other through; other sums are hand-computed.
   function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h0) return b;
      if (b == 32'h0) return a;
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h40400000, 32'h40400000}: return 32'h40C00000;
         {32'h40000000, 32'hC0800000}: return 32'hC0000000;
         default:                      return 32'hFFFFFFFF;
      endcase
   endfunction

   always_comb bus.add_res = add_model(bus.add_op1, bus.add_op2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.sum_ready = 1'b0;

      tick();
      chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h0);
      chk("rst_sum_valid", {31'h0, bus.sum_valid}, 32'h0);
      chk("rst_sum_data",  bus.sum_data,           32'h0);
      chk("rst_busy",      {31'h0, bus.busy},      32'h0);
      chk("rst_add_op1",   bus.add_op1,            32'h0);
      rst = 1'b0;

      // Three-element sum
      tick();
      bus.start = 1'b1; bus.len = 8'd3;
      tick();
      bus.start = 1'b0;
      chk("t1_busy",     {31'h0, bus.busy},     32'h1);
      chk("t1_in_ready", {31'h0, bus.in_ready}, 32'h1);
      bus.in_valid = 1'b1; bus.in_data = 32'h3F800000;
      tick();
      chk("t1_acc1", bus.add_op1, 32'h3F800000);
      bus.in_data = 32'h40000000;
      tick();
      chk("t1_acc2", bus.add_op1, 32'h40400000);
      bus.in_data = 32'h40400000;
      tick();
      bus.in_valid = 1'b0;
      chk("t1_sum_valid", {31'h0, bus.sum_valid}, 32'h1);
      chk("t1_sum_data",  bus.sum_data,           32'h40C00000);
      chk("t1_done_rdy",  {31'h0, bus.in_ready},  32'h0);
      chk("t1_done_busy", {31'h0, bus.busy},      32'h1);
      bus.sum_ready = 1'b1;
      tick();
      bus.sum_ready = 1'b0;
      chk("t1_idle_busy",  {31'h0, bus.busy},      32'h0);
      chk("t1_idle_valid", {31'h0, bus.sum_valid}, 32'h0);

      // Bubbles and back-pressure
      bus.start = 1'b1; bus.len = 8'd2;
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'h3F800000;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_bubble_acc",   bus.add_op1,            32'h3F800000);
         chk("t2_bubble_valid", {31'h0, bus.sum_valid}, 32'h0);
      end
      bus.in_valid = 1'b1; bus.in_data = 32'h40000000;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", {31'h0, bus.sum_valid}, 32'h1);
         chk("t2_hold_data",  bus.sum_data,           32'h40400000);
         chk("t2_hold_rdy",   {31'h0, bus.in_ready},  32'h0);
         bus.in_valid = (i % 2 == 0);
         bus.in_data  = 32'h3F800000;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("t2_after_pulses", bus.sum_data, 32'h40400000);
      bus.sum_ready = 1'b1;
      tick();
      bus.sum_ready = 1'b0;
      chk("t2_idle_valid", {31'h0, bus.sum_valid}, 32'h0);

      // Zero-length job
      bus.start = 1'b1; bus.len = 8'd0;
      tick();
      bus.start = 1'b0;
      chk("t3_valid",    {31'h0, bus.sum_valid}, 32'h1);
      chk("t3_data",     bus.sum_data,           32'h0);
      chk("t3_in_ready", {31'h0, bus.in_ready},  32'h0);
      bus.sum_ready = 1'b1;
      tick();
      bus.sum_ready = 1'b0;
      chk("t3_idle_valid", {31'h0, bus.sum_valid}, 32'h0);
      chk("t3_idle_rdy",   {31'h0, bus.in_ready},  32'h0);

      // Start ignored outside IDLE
      bus.start = 1'b1; bus.len = 8'd2;
      tick();
      bus.len = 8'd5;
      bus.in_valid = 1'b1; bus.in_data = 32'h40000000;
      tick();
      bus.start = 1'b0;
      bus.in_data = 32'hC0800000;
      tick();
      bus.in_valid = 1'b0;
      chk("t4_valid", {31'h0, bus.sum_valid}, 32'h1);
      chk("t4_data",  bus.sum_data,           32'hC0000000);
      bus.start = 1'b1;
      tick();
      chk("t4_done_start", {31'h0, bus.sum_valid}, 32'h1);
      bus.sum_ready = 1'b1;
      tick();
      bus.start = 1'b0; bus.sum_ready = 1'b0;
      chk("t4_handoff_busy", {31'h0, bus.busy}, 32'h0);

      // Asynchronous reset mid-job
      bus.start = 1'b1; bus.len = 8'd4;
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'h3F800000;
      tick();
      bus.in_data = 32'h40000000;
      tick();
      bus.in_valid = 1'b0;
      chk("t5_pre_rst_acc", bus.add_op1, 32'h40400000);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_busy",  {31'h0, bus.busy},     32'h0);
      chk("t5_rst_rdy",   {31'h0, bus.in_ready}, 32'h0);
      chk("t5_rst_acc",   bus.add_op1,           32'h0);
      chk("t5_rst_valid", {31'h0, bus.sum_valid}, 32'h0);
      tick();
      rst = 1'b0;
      bus.start = 1'b1; bus.len = 8'd1;
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'h3F800000;
      tick();
      bus.in_valid = 1'b0;
      chk("t5_valid", {31'h0, bus.sum_valid}, 32'h1);
      chk("t5_data",  bus.sum_data,           32'h3F800000);
      bus.sum_ready = 1'b1;
      tick();
      bus.sum_ready = 1'b0;

      // Maximum length
      bus.start = 1'b1; bus.len = 8'd255;
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'h0;
      accepts = 0;
      cycles  = 0;
      while (!bus.sum_valid && cycles < 400) begin
         if (bus.in_ready && bus.in_valid) accepts++;
         tick();
         cycles++;
      end
      bus.in_valid = 1'b0;
      chk("t6_accepts", 32'(accepts), 32'd255);
      chk("t6_valid",   {31'h0, bus.sum_valid}, 32'h1);
      chk("t6_data",    bus.sum_data,           32'h0);
      bus.sum_ready = 1'b1;
      tick();
      bus.sum_ready = 1'b0;
      chk("t6_idle_busy", {31'h0, bus.busy}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fp_sum_sequencer.md
Name: fp_sum_sequencer

Overview:
- Sequential accumulator that sits around the team's combinational single-precision adder, feeding its operands and capturing its result.
- It accepts a length-prefixed stream of IEEE-754 single-precision words over a valid/ready handshake and sums them one per cycle: add_op1 = running sum, add_op2 = incoming word, add_res captured.
- It presents the final sum on a valid/ready output port.
- The adder is instantiated beside this block at the next level up. This block contains no floating-point arithmetic of its own.

Parameters:
- LEN_W, 8, width of the element-count input; a job is 0 to 2^LEN_W-1 elements.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  pulse; begins a job when in IDLE.
- len  input  LEN_W  element count, sampled with start.
- in_valid  input  1  in_data is valid.
- in_data  input  32  element to add (IEEE-754 single).
- in_ready  output  1  block accepts in_data this cycle.
- add_op1  output  32  to the adder's operand1; always equals the accumulator register.
- add_op2  output  32  to the adder's operand2; always equals in_data.
- add_res  input  32  from the adder's result; combinational function of add_op1/add_op2.
- sum_valid  output  1  sum_data holds a completed sum.
- sum_data  output  32  completed sum.
- sum_ready  input  1  consumer takes sum_data.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (async, immediate): state=IDLE, acc=32'h0, cnt=0, len_q=0. All outputs then read: in_ready=0, sum_valid=0, sum_data=0, busy=0, add_op1=0.
- Reset asserted mid-job aborts the job with no sum emitted. The first rising clk edge after deassertion is processed normally.
- State IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1: acc<=0, cnt<=0, len_q<=len.
  - If len==0, go to DONE (sum 0x00000000); otherwise go to ACCUM.
  - start with len sampled on the same edge.
- State ACCUM:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: acc<=add_res, cnt<=cnt+1.
  - If cnt==len_q-1 on that edge, go to DONE.
  - Cycles with in_valid=0 leave acc and cnt unchanged; bubbles are allowed anywhere.
  - start is ignored.
- State DONE:
  - in_ready=0, sum_valid=1, sum_data=acc.
  - sum_data is held stable while sum_valid=1 and sum_ready=0.
  - sum_valid&&sum_ready: go to IDLE.
  - start is ignored in DONE, including on the handoff edge. A new job needs start in IDLE, so there is at least one idle cycle between jobs.
- Latency:
  - The last element is accepted on edge N; sum_valid rises in the following cycle.
  - Minimum job time is len+2 cycles, from start to return to IDLE with sum_ready held high.
- Accumulation arithmetic:
  - The first element passes unchanged because the adder returns the other operand when one operand is exactly 0x00000000.
  - No rounding, NaN/Inf or denormal handling is added. Sum results are whatever add_res returns.
  - Exact cancellation (x + -x, equal exponent and mantissa) is outside the supported input set.
- Counter:
  - cnt is LEN_W bits.
  - len=2^LEN_W-1 must complete without wrap: the compare against len_q-1 happens before increment.
- Outputs in_ready, sum_valid and busy are decoded from the state register only, with no combinational path from in_valid or sum_ready.

Test Plan:
- Three-element sum: reset, start with len=3, feed 0x3F800000, 0x40000000, 0x40400000 back-to-back -> sum_valid one cycle after the third accept, sum_data=0x40C00000 (6.0), busy high from start+1 until handoff.
- Bubbles and back-pressure: len=2, feed 0x3F800000, idle 3 cycles, then 0x40000000; hold sum_ready=0 for 5 cycles -> sum_data stays 0x40400000 with sum_valid=1 throughout; in_ready=0 in DONE; in_valid pulses while in DONE change nothing.
- Zero-length job: start with len=0 -> DONE on the next cycle, sum_data=0x00000000, in_ready never asserts.
- Ignored start: assert start with len=5 during an ACCUM job of len=2 (0x40000000, 0xC0800000) -> the job finishes after 2 elements with sum_data=0xC0000000 (-2.0); the second start has no effect.
- Reset mid-job: len=4, accept 2 elements, assert rst asynchronously between edges -> outputs immediately at reset values; after release, a new len=1 job with 0x3F800000 returns exactly 0x3F800000.
- Maximum length: LEN_W=8, len=255, all elements 0x00000000 -> exactly 255 accepts, then sum_valid with sum_data=0x00000000; cnt does not wrap.
